sync_fifo_level: RTL and testbench

Single-clock, parametrised FIFO. It is the same-domain successor to the team's dual-clock pointer FIFO. It adds:
- a selectable standard or first-word-fall-through (FWFT) read mode,
- a registered fill level,
- programmable almost-full and almost-empty flags,
- sticky overflow and underflow error flags,
- a synchronous flush.

It sits between sample-producing and sample-consuming logic inside the measurement datapath, in a single clock domain.

---
 rtl/sync_fifo_level_if.sv | 33 +++
 rtl/sync_fifo_level.sv | 122 ++++++++++++
 tb/tb_sync_fifo_level.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_level_if.sv
// Handshake and status bundle between a sync_fifo_level and its producer/consumer.
// master = the logic driving the FIFO, slave = the FIFO itself.
interface sync_fifo_level_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int FIFO_DEPTH_WIDTH = 4
);
  logic                        flush;
  logic                        data_in_vld;
  logic [DATA_WIDTH-1:0]       data_in;
  logic                        fifo_full;
  logic                        almost_full;
  logic                        read_req;
  logic                        data_out_vld;
  logic [DATA_WIDTH-1:0]       data_out;
  logic                        fifo_empty;
  logic                        almost_empty;
  logic [FIFO_DEPTH_WIDTH:0]   fill_level;
  logic                        overflow;
  logic                        underflow;
  logic                        clr_err;

  modport master (
    output flush, data_in_vld, data_in, read_req, clr_err,
    input  fifo_full, almost_full, data_out_vld, data_out, fifo_empty,
           almost_empty, fill_level, overflow, underflow
  );

  modport slave (
    input  flush, data_in_vld, data_in, read_req, clr_err,
    output fifo_full, almost_full, data_out_vld, data_out, fifo_empty,
           almost_empty, fill_level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with registered fill level, almost flags, sticky errors and flush.
// Latency: standard mode data 1 cycle after read_req; FWFT shows head the cycle after write.
// Backpressure: writes dropped while full (overflow), reads ignored while empty (underflow).
module sync_fifo_level #(
  parameter int DATA_WIDTH       = 32,
  parameter int FIFO_DEPTH       = 16,
  parameter int FIFO_DEPTH_WIDTH = $clog2(FIFO_DEPTH),
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_TH   = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_TH  = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_level_if.slave bus
);
  localparam int AW = FIFO_DEPTH_WIDTH;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(ALMOST_FULL_TH);
  localparam logic [AW:0] AE_L    = (AW+1)'(ALMOST_EMPTY_TH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_level: FIFO_DEPTH must be a power of two >= 2");
    end
    if (FIFO_DEPTH_WIDTH != $clog2(FIFO_DEPTH)) begin : g_bad_aw
      $error("sync_fifo_level: FIFO_DEPTH_WIDTH must equal clog2(FIFO_DEPTH)");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("sync_fifo_level: FWFT must be 0 or 1");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > FIFO_DEPTH) begin : g_bad_af
      $error("sync_fifo_level: ALMOST_FULL_TH out of range 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > FIFO_DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_level: ALMOST_EMPTY_TH out of range 0..FIFO_DEPTH-1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           level;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;
  logic [AW-1:0]         rd_idx;

  // Flags decode only the registered level, never this cycle's requests.
  assign full   = (level == DEPTH_L);
  assign empty  = (level == '0);
  assign wr_en  = bus.data_in_vld & ~full  & ~bus.flush;
  assign rd_en  = bus.read_req    & ~empty & ~bus.flush;
  assign rd_idx = rd_ptr[AW-1:0];

  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (level >= AF_L);
  assign bus.almost_empty = (level <= AE_L);
  assign bus.fill_level   = level;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr[AW-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      case ({wr_en, rd_en})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.data_in_vld && full && !bus.flush) ovf_q <= 1'b1;
      else if (bus.clr_err)                      ovf_q <= 1'b0;
      if (bus.read_req && empty && !bus.flush)   udf_q <= 1'b1;
      else if (bus.clr_err)                      udf_q <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dvld_q;
      always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
          dout_q <= '0;
          dvld_q <= 1'b0;
        end else begin
          dvld_q <= rd_en;
          dout_q <= rd_en ? mem[rd_idx] : '0;
        end
      end
      assign bus.data_out_vld = dvld_q;
      assign bus.data_out     = dout_q;
    end else begin : g_fwft
      assign bus.data_out_vld = ~empty;
      assign bus.data_out     = empty ? '0 : mem[rd_idx];
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_level.sv
// Drives a standard-mode and an FWFT instance with identical stimulus and checks both
// against a queue-based model of the FIFO rules.
module tb_sync_fifo_level;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wv = 1'b0, rr = 1'b0, fl = 1'b0, ce = 1'b0;
  logic [DW-1:0] wd = '0;

  always #5 clk = ~clk;

  sync_fifo_level_if #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW)) s_if ();
  sync_fifo_level_if #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW)) f_if ();

  assign s_if.flush = fl;  assign s_if.data_in_vld = wv;  assign s_if.data_in = wd;
  assign s_if.read_req = rr;  assign s_if.clr_err = ce;
  assign f_if.flush = fl;  assign f_if.data_in_vld = wv;  assign f_if.data_in = wd;
  assign f_if.read_req = rr;  assign f_if.clr_err = ce;

  sync_fifo_level #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .bus(s_if)
  );
  sync_fifo_level #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .bus(f_if)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: contents as a queue, plus sticky flags and the standard-mode output register.
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0, m_udf = 1'b0, m_dvld = 1'b0;
  logic [DW-1:0] m_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int            lvl  = q.size();
    logic [DW-1:0] head = (lvl > 0) ? q[0] : '0;
    chk("std_level",   32'(s_if.fill_level),   lvl);
    chk("std_full",    32'(s_if.fifo_full),    32'(lvl == DEPTH));
    chk("std_afull",   32'(s_if.almost_full),  32'(lvl >= DEPTH - 2));
    chk("std_empty",   32'(s_if.fifo_empty),   32'(lvl == 0));
    chk("std_aempty",  32'(s_if.almost_empty), 32'(lvl <= 2));
    chk("std_ovf",     32'(s_if.overflow),     32'(m_ovf));
    chk("std_udf",     32'(s_if.underflow),    32'(m_udf));
    chk("std_dvld",    32'(s_if.data_out_vld), 32'(m_dvld));
    chk("std_dout",    32'(s_if.data_out),     32'(m_dout));
    chk("fwft_level",  32'(f_if.fill_level),   lvl);
    chk("fwft_ovf",    32'(f_if.overflow),     32'(m_ovf));
    chk("fwft_udf",    32'(f_if.underflow),    32'(m_udf));
    chk("fwft_dvld",   32'(f_if.data_out_vld), 32'(lvl > 0));
    chk("fwft_dout",   32'(f_if.data_out),     32'(head));
  endtask

  task automatic cycle(input bit r, input bit w, input logic [DW-1:0] d,
                       input bit rd, input bit f, input bit c);
    bit full_now, empty_now;
    rst = r; wv = w; wd = d; rr = rd; fl = f; ce = c;
    full_now  = (q.size() == DEPTH);
    empty_now = (q.size() == 0);
    if (r) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dvld = 1'b0; m_dout = '0;
    end else if (f) begin
      q.delete(); m_dvld = 1'b0; m_dout = '0;
      if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      m_dvld = rd && !empty_now;
      m_dout = m_dvld ? q[0] : '0;
      if (m_dvld) void'(q.pop_front());
      if (w && !full_now) q.push_back(d);
      m_ovf = (w && full_now)   ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_udf = (rd && empty_now) ? 1'b1 : (c ? 1'b0 : m_udf);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] v;
    // Reset state
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_empty", 32'(s_if.fifo_empty), 1);
    chk("rst_aempty", 32'(s_if.almost_empty), 1);
    chk("rst_dout", 32'(s_if.data_out), 0);

    // Fill with 0x01..0x08, then drain in order
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, DW'(i), 0, 0, 0);
      chk("fill_step", 32'(s_if.fill_level), i);
    end
    chk("full_after_8", 32'(s_if.fifo_full), 1);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      chk("drain_data", 32'(s_if.data_out), i);
      chk("drain_vld", 32'(s_if.data_out_vld), 1);
    end
    chk("empty_after_drain", 32'(s_if.fifo_empty), 1);

    // Overflow on full, clear, then set-wins-over-clear
    for (int i = 0; i < 8; i++) cycle(0, 1, DW'(8'h10 + i), 0, 0, 0);
    cycle(0, 1, 8'hAA, 0, 0, 0);
    chk("ovf_set", 32'(s_if.overflow), 1);
    chk("ovf_level", 32'(s_if.fill_level), 8);
    cycle(0, 0, 0, 0, 0, 1);
    chk("ovf_cleared", 32'(s_if.overflow), 0);
    cycle(0, 1, 8'hAB, 0, 0, 1);
    chk("ovf_set_wins", 32'(s_if.overflow), 1);
    cycle(0, 1, 8'hAC, 1, 0, 0);      // full: read accepted, write rejected
    chk("full_rw_level", 32'(s_if.fill_level), 7);
    cycle(0, 0, 0, 0, 1, 1);

    // Underflow with simultaneous write into empty FIFO
    cycle(0, 1, 8'h55, 1, 0, 0);
    chk("udf_set", 32'(s_if.underflow), 1);
    chk("udf_no_vld", 32'(s_if.data_out_vld), 0);
    chk("udf_level", 32'(s_if.fill_level), 1);

    // Level 4, simultaneous read/write across pointer wrap
    for (int i = 0; i < 3; i++) cycle(0, 1, DW'($urandom), 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, DW'($urandom), 1, 0, 0);
    chk("steady_level", 32'(s_if.fill_level), 4);

    // FWFT visibility and pop
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 1, 8'h3C, 0, 0, 0);
    chk("fwft_show", 32'(f_if.data_out), 32'h3C);
    chk("fwft_show_vld", 32'(f_if.data_out_vld), 1);
    cycle(0, 0, 0, 1, 0, 0);
    chk("fwft_popped", 32'(f_if.data_out_vld), 0);

    // Flush keeps overflow; reset mid-stream clears everything
    for (int i = 0; i < 9; i++) cycle(0, 1, DW'(i), 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, DW'(8'h60 + i), 0, 0, 0);
    cycle(0, 1, 8'h77, 1, 1, 0);
    chk("flush_level", 32'(s_if.fill_level), 0);
    chk("flush_keeps_ovf", 32'(s_if.overflow), 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, DW'(8'h90 + i), 0, 0, 0);
    cycle(1, 1, 8'hEE, 1, 0, 0);
    chk("rst_mid_ovf", 32'(s_if.overflow), 0);
    chk("rst_mid_level", 32'(f_if.fill_level), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v = DW'($urandom);
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6), v,
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
